pc_fetch: RTL and testbench

//  Owns the architectural PC register and the instruction-fetch handshake; the consumer end of the next-PC path.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/pc_align_chk.sv | 13 +
 rtl/pc_fetch.sv | 126 ++++++++++++
 tb/tb_pc_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: FSM state encoding, default PC vectors and datapath widths.
package cpu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'h0000_4180;

  // Sequential successor of a PC; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] p);
    return p + XLEN'(4);
  endfunction

endpackage

// File: rtl/pc_align_chk.sv
// Combinational next-PC alignment check: word-aligned address plus a trap flag for a misaligned npc.
module pc_align_chk
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] npc,
  output logic [XLEN-1:0] aligned_pc,
  output logic            trap
);

  assign aligned_pc = {npc[XLEN-1:2], 2'b00};
  assign trap       = |npc[1:0];

endmodule

// File: rtl/pc_fetch.sv
// PC register and instruction-fetch handshake (imem req/ack, decode valid/ready).
// Optional misaligned-npc trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
`ifdef PC_ALIGN_CHECK_EN
  , parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEF
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    npc,
  output logic [XLEN-1:0]    npc_t,
  output logic [XLEN-1:0]    pc,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               misalign_exc,
  output logic [XLEN-1:0]    badvaddr
);

  logic [0:0]         state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic [XLEN-1:0]    npc_aligned;

`ifdef PC_ALIGN_CHECK_EN
  logic               npc_trap;
  logic               misalign_exc_q, misalign_exc_d;
  logic [XLEN-1:0]    badvaddr_q, badvaddr_d;

  pc_align_chk u_align_chk (
    .npc        (npc),
    .aligned_pc (npc_aligned),
    .trap       (npc_trap)
  );
`else
  assign npc_aligned = npc & ~XLEN'(3);
`endif

  // Next-state and datapath: fetch in S_REQ, hold for decode in S_HOLD.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
`ifdef PC_ALIGN_CHECK_EN
    misalign_exc_d = 1'b0;
    badvaddr_d     = badvaddr_q;
`endif
    case (state_q)
      S_REQ: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
`ifdef PC_ALIGN_CHECK_EN
          if (npc_trap) begin
            pc_d           = EXC_VECTOR;
            badvaddr_d     = npc;
            misalign_exc_d = 1'b1;
          end else begin
            pc_d = npc_aligned;
          end
`else
          pc_d = npc_aligned;
`endif
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_exc_q <= 1'b0;
      badvaddr_q     <= '0;
    end else begin
      misalign_exc_q <= misalign_exc_d;
      badvaddr_q     <= badvaddr_d;
    end
  end

  assign misalign_exc = misalign_exc_q;
  assign badvaddr     = badvaddr_q;
`else
  assign misalign_exc = 1'b0;
  assign badvaddr     = '0;
`endif

  // Request drops with rst so memory never sees a fetch during reset.
  assign imem_req    = (state_q == S_REQ) && !rst;
  assign imem_addr   = imem_req ? pc_q : '0;
  assign npc_t       = pc_plus4(pc_q);
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed vector table, corner sequences and a random run against a reference model.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc;
  logic [31:0] npc_t;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        misalign_exc;
  logic [31:0] badvaddr;

  pc_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .npc          (npc),
    .npc_t        (npc_t),
    .pc           (pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .misalign_exc (misalign_exc),
    .badvaddr     (badvaddr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: "have an instruction waiting for decode" plus the architectural values.
  logic [31:0] m_pc;
  logic        m_have;
  logic [31:0] m_instr;
  logic        m_exc;
  logic [31:0] m_bad;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic [31:0] npc;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_have = 1'b0; m_instr = 32'h0; m_exc = 1'b0; m_bad = 32'h0;
  endtask

  task automatic model_edge(input logic ack, input logic [31:0] rd, input logic rdy, input logic [31:0] n);
    m_exc = 1'b0;
    if (!m_have) begin
      if (ack) begin m_instr = rd; m_have = 1'b1; end
    end else if (rdy) begin
      m_have = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      if (n[1:0] != 2'b00) begin
        m_pc = 32'h0000_4180; m_bad = n; m_exc = 1'b1;
      end else begin
        m_pc = n;
      end
`else
      m_pc = n - (n % 4);
`endif
    end
  endtask

  task automatic check_model();
    chk("pc", pc, m_pc);
    chk("npc_t", npc_t, m_pc + 32'd4);
    chk("imem_req", imem_req, m_have ? 32'd0 : 32'd1);
    chk("imem_addr", imem_addr, m_have ? 32'd0 : m_pc);
    chk("instr", instr, m_instr);
    chk("instr_valid", instr_valid, m_have ? 32'd1 : 32'd0);
    chk("misalign_exc", misalign_exc, m_exc ? 32'd1 : 32'd0);
    chk("badvaddr", badvaddr, m_bad);
  endtask

  // One clock: drive inputs, let the edge happen, advance model, check at the falling edge.
  task automatic step(input logic ack, input logic [31:0] rd, input logic rdy, input logic [31:0] n);
    imem_ack = ack; imem_rdata = rd; instr_ready = rdy; npc = n;
    @(posedge clk);
    model_edge(ack, rd, rdy, n);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h0,         1'b0, 32'h0,    32'h3000, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,         1'b0, 32'h0,    32'h3000, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,         1'b1, 32'h9990, 32'h3000, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h2408_0001, 1'b0, 32'h0,    32'h3000, 1'b1, 32'h2408_0001};
    vecs[4]  = '{1'b0, 32'h0,         1'b0, 32'h1234, 32'h3000, 1'b1, 32'h2408_0001};
    vecs[5]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 32'h3040, 32'h3000, 1'b1, 32'h2408_0001};
    vecs[6]  = '{1'b0, 32'h0,         1'b0, 32'h5554, 32'h3000, 1'b1, 32'h2408_0001};
    vecs[7]  = '{1'b0, 32'h0,         1'b1, 32'h3040, 32'h3040, 1'b0, 32'h2408_0001};
    vecs[8]  = '{1'b1, 32'h2408_0001, 1'b1, 32'h0,    32'h3040, 1'b1, 32'h2408_0001};
    vecs[9]  = '{1'b0, 32'h0,         1'b1, 32'h3044, 32'h3044, 1'b0, 32'h2408_0001};
    vecs[10] = '{1'b1, 32'h2408_0002, 1'b0, 32'h0,    32'h3044, 1'b1, 32'h2408_0002};
    vecs[11] = '{1'b1, 32'h0,         1'b1, 32'h3048, 32'h3048, 1'b0, 32'h2408_0002};

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0; npc = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h3000);
    chk("rst_req", imem_req, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", instr_valid, 32'd0);
    chk("rst_exc", misalign_exc, 32'd0);
    chk("rst_bad", badvaddr, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_req", imem_req, 32'd1);
    chk("rel_addr", imem_addr, 32'h3000);
    chk("rel_npc_t", npc_t, 32'h3004);

    // Wait states, decode stall with toggling npc, zero-wait stream.
    for (int i = 0; i < 12; i++) begin
      imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
      instr_ready = vecs[i].rdy; npc = vecs[i].npc;
      @(posedge clk);
      model_edge(vecs[i].ack, vecs[i].rdata, vecs[i].rdy, vecs[i].npc);
      @(negedge clk);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_valid", i), instr_valid, vecs[i].exp_valid ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
      chk($sformatf("vec%0d_req", i), imem_req, vecs[i].exp_valid ? 32'd0 : 32'd1);
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_valid ? 32'd0 : vecs[i].exp_pc);
    end

    // Async reset in the middle of a pending fetch.
    step(1'b0, 32'h0, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_pc", pc, 32'h3000);
    chk("midrst_req", imem_req, 32'd0);
    chk("midrst_valid", instr_valid, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_model();

    // PC wrap at the top of the address space.
    step(1'b1, 32'h1111_0000, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_npc_t", npc_t, 32'h0);
    step(1'b1, 32'h1111_0001, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 32'h0);
    chk("wrap_pc0", pc, 32'h0);
    chk("wrap_addr0", imem_addr, 32'h0);

    // Misaligned next PC.
    step(1'b1, 32'h1111_0002, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 32'h3006);
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_pc", pc, 32'h4180);
    chk("mis_exc", misalign_exc, 32'd1);
    chk("mis_bad", badvaddr, 32'h3006);
`else
    chk("mis_pc", pc, 32'h3004);
    chk("mis_exc", misalign_exc, 32'd0);
`endif
    step(1'b0, 32'h0, 1'b0, 32'h0);
    chk("mis_exc_after", misalign_exc, 32'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic        a, r;
      logic [31:0] n;
      int unsigned sel;
      a = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel < 6)      n = m_pc + 32'd4;
      else if (sel < 8) n = $urandom() & 32'hFFFF_FFFC;
      else              n = $urandom();
      step(a, $urandom(), r, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
